// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/writeback sequencer for a shared mult/div unit.
// Ports: clock, ctrl_reset_n (async, active-low); req_* issue side and
// req_kill flush; stall back to the pipeline; md_* to/from the multdiv
// unit; wb_* writeback bundle; md_timeout sticky watchdog flag.
// Build option: define MD_TIMEOUT_EN to enable the WAIT watchdog.
module md_issue_ctrl #(
    parameter int RD_W           = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clock,
    input  logic            ctrl_reset_n,
    input  logic            req_valid,
    input  logic            req_is_div,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [RD_W-1:0] req_rd,
    input  logic            req_kill,
    output logic            stall,
    output logic [31:0]     md_operandA,
    output logic [31:0]     md_operandB,
    output logic            md_ctrl_MULT,
    output logic            md_ctrl_DIV,
    input  logic [31:0]     md_result,
    input  logic            md_exception,
    input  logic            md_resultRDY,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            wb_exception,
    output logic            md_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            accept;
    logic            wb_load;
    logic [31:0]     wb_data_nx;
    logic            wb_exc_nx;
    logic [RD_W-1:0] rd_q;
    logic            is_div_q;
    logic            stall_q;
    logic [31:0]     op_a_q;
    logic [31:0]     op_b_q;
    logic [RD_W-1:0] wb_rd_q;
    logic [31:0]     wb_data_q;
    logic            wb_exc_q;
    logic            fire;

`ifdef MD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          timeout_q;
`else
    // Watchdog absent: parameter kept only for a uniform interface.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        wb_load    = 1'b0;
        wb_data_nx = wb_data_q;
        wb_exc_nx  = wb_exc_q;
        fire       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && !req_kill) begin
                    accept = 1'b1;
                    if (req_is_div && (req_b == 32'd0)) begin
                        // Divide by zero never reaches the unit.
                        state_nx   = DONE;
                        wb_load    = 1'b1;
                        wb_data_nx = 32'd0;
                        wb_exc_nx  = 1'b1;
                    end else begin
                        state_nx = START;
                    end
                end
            end
            START: begin
                // Ready is ignored here: it may be left over from a prior op.
                state_nx = req_kill ? IDLE : WAIT;
            end
            WAIT: begin
                if (req_kill) begin
                    state_nx = IDLE;
                end else if (md_resultRDY) begin
                    state_nx   = DONE;
                    wb_load    = 1'b1;
                    wb_data_nx = md_result;
                    wb_exc_nx  = md_exception;
                end
`ifdef MD_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx   = DONE;
                    wb_load    = 1'b1;
                    wb_data_nx = 32'd0;
                    wb_exc_nx  = 1'b1;
                    fire       = 1'b1;
                end
`endif
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state     <= IDLE;
            stall_q   <= 1'b0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            rd_q      <= '0;
            is_div_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= 32'd0;
            wb_exc_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            stall_q <= (state_nx != IDLE);
            if (accept) begin
                op_a_q   <= req_a;
                op_b_q   <= req_b;
                rd_q     <= req_rd;
                is_div_q <= req_is_div;
            end
            if (wb_load) begin
                // The divide-by-zero path loads in the accept cycle.
                wb_rd_q   <= accept ? req_rd : rd_q;
                wb_data_q <= wb_data_nx;
                wb_exc_q  <= wb_exc_nx;
            end
        end
    end

`ifdef MD_TIMEOUT_EN
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == START) begin
                cnt <= '0;
            end else if (state == WAIT && !req_kill && !md_resultRDY) begin
                cnt <= cnt + 1'b1;
            end
            if (fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign md_timeout = timeout_q;
`else
    assign md_timeout = 1'b0;
`endif

    assign stall        = stall_q;
    assign md_operandA  = op_a_q;
    assign md_operandB  = op_b_q;
    assign md_ctrl_MULT = (state == START) && !is_div_q;
    assign md_ctrl_DIV  = (state == START) && is_div_q;
    assign wb_valid     = (state == DONE) && !req_kill;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_exception = wb_exc_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed self-checking bench for md_issue_ctrl.
// Covers multiply, divide-by-zero, stale ready, kill, reset, watchdog.
module tb_md_issue_ctrl;

`ifdef MD_TIMEOUT_EN
    localparam int TO_CYC   = 8;
    localparam int MUL_WAIT = 5;
`else
    localparam int TO_CYC   = 64;
    localparam int MUL_WAIT = 17;
`endif

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        req_valid;
    logic        req_is_div;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        req_kill;
    logic        stall;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        md_timeout;

    int checks = 0;
    int errors = 0;
    int n_wb   = 0;
    int n_mul  = 0;
    int n_div  = 0;
    int base_wb;
    int base_mul;
    int base_div;

    md_issue_ctrl #(
        .RD_W(5),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clock(clock),
        .ctrl_reset_n(ctrl_reset_n),
        .req_valid(req_valid),
        .req_is_div(req_is_div),
        .req_a(req_a),
        .req_b(req_b),
        .req_rd(req_rd),
        .req_kill(req_kill),
        .stall(stall),
        .md_operandA(md_operandA),
        .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT),
        .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result),
        .md_exception(md_exception),
        .md_resultRDY(md_resultRDY),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .wb_exception(wb_exception),
        .md_timeout(md_timeout)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wb_valid)     n_wb++;
        if (md_ctrl_MULT) n_mul++;
        if (md_ctrl_DIV)  n_div++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mark();
        base_wb  = n_wb;
        base_mul = n_mul;
        base_div = n_div;
    endtask

    task automatic issue(input logic dv, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_is_div = dv;
        req_a      = a;
        req_b      = b;
        req_rd     = rd;
    endtask

    task automatic idle_in();
        req_valid  = 1'b0;
        req_is_div = 1'b0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        req_rd     = 5'd0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_opa"}, md_operandA, 32'd0);
        chk({tag, "_opb"}, md_operandB, 32'd0);
        chk({tag, "_mult"}, 32'(md_ctrl_MULT), 32'd0);
        chk({tag, "_div"}, 32'(md_ctrl_DIV), 32'd0);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wbd"}, wb_data, 32'd0);
        chk({tag, "_wbx"}, 32'(wb_exception), 32'd0);
        chk({tag, "_to"}, 32'(md_timeout), 32'd0);
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        req_kill     = 1'b0;
        md_result    = 32'd0;
        md_exception = 1'b0;
        md_resultRDY = 1'b0;
        idle_in();
        #3;
        chk_zero("rst");
        repeat (2) @(posedge clock);
        @(negedge clock);
        ctrl_reset_n = 1'b1;

        // Multiply 7 * -3, first request right after release.
        mark();
        issue(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        step();
        idle_in();
        chk("mul_start", 32'(md_ctrl_MULT), 32'd1);
        chk("mul_stall_s", 32'(stall), 32'd1);
        chk("mul_opa", md_operandA, 32'd7);
        chk("mul_opb", md_operandB, 32'hFFFF_FFFD);
        step();
        chk("mul_pulse_end", 32'(md_ctrl_MULT), 32'd0);
        for (int i = 1; i < MUL_WAIT; i++) begin
            step();
        end
        chk("mul_wait_stall", 32'(stall), 32'd1);
        chk("mul_wait_nowb", 32'(n_wb - base_wb), 32'd0);
        md_resultRDY = 1'b1;
        md_result    = 32'hFFFF_FFEB;
        md_exception = 1'b0;
        step();
        md_resultRDY = 1'b0;
        md_result    = 32'd0;
        chk("mul_wbv", 32'(wb_valid), 32'd1);
        chk("mul_wbd", wb_data, 32'hFFFF_FFEB);
        chk("mul_wbx", 32'(wb_exception), 32'd0);
        chk("mul_wbrd", 32'(wb_rd), 32'd5);
        chk("mul_stall_d", 32'(stall), 32'd1);
        chk("mul_opa_d", md_operandA, 32'd7);
        step();
        chk("mul_idle_stall", 32'(stall), 32'd0);
        chk("mul_hold_d", wb_data, 32'hFFFF_FFEB);
        chk("mul_npulse", 32'(n_mul - base_mul), 32'd1);
        chk("mul_nwb", 32'(n_wb - base_wb), 32'd1);

        // Divide by zero: writeback next cycle, no start pulse.
        mark();
        issue(1'b1, 32'd10, 32'd0, 5'd9);
        step();
        idle_in();
        chk("dz_wbv", 32'(wb_valid), 32'd1);
        chk("dz_wbx", 32'(wb_exception), 32'd1);
        chk("dz_wbd", wb_data, 32'd0);
        chk("dz_wbrd", 32'(wb_rd), 32'd9);
        chk("dz_stall", 32'(stall), 32'd1);
        step();
        chk("dz_idle", 32'(stall), 32'd0);
        chk("dz_ndiv", 32'(n_div - base_div), 32'd0);
        chk("dz_nwb", 32'(n_wb - base_wb), 32'd1);

        // Stale ready held through START is ignored.
        mark();
        md_resultRDY = 1'b1;
        md_result    = 32'h1111_1111;
        issue(1'b1, 32'd100, 32'd7, 5'd3);
        step();
        idle_in();
        md_result = 32'd14;
        chk("st_div", 32'(md_ctrl_DIV), 32'd1);
        chk("st_nowb_s", 32'(wb_valid), 32'd0);
        step();
        chk("st_nowb_w", 32'(wb_valid), 32'd0);
        step();
        md_resultRDY = 1'b0;
        chk("st_wbv", 32'(wb_valid), 32'd1);
        chk("st_wbd", wb_data, 32'd14);
        chk("st_wbrd", 32'(wb_rd), 32'd3);
        step();
        chk("st_nwb", 32'(n_wb - base_wb), 32'd1);
        chk("st_ndiv", 32'(n_div - base_div), 32'd1);

        // Ready while idle has no effect.
        mark();
        md_resultRDY = 1'b1;
        md_result    = 32'hDEAD_BEEF;
        step();
        step();
        md_resultRDY = 1'b0;
        chk("idle_rdy_d", wb_data, 32'd14);
        chk("idle_rdy_nwb", 32'(n_wb - base_wb), 32'd0);

        // Kill in WAIT cycle 5 beats a simultaneous ready.
        mark();
        issue(1'b0, 32'd1, 32'd2, 5'd7);
        step();
        idle_in();
        step();
        repeat (4) step();
        req_kill     = 1'b1;
        md_resultRDY = 1'b1;
        md_result    = 32'hBAD0_BAD0;
        step();
        req_kill     = 1'b0;
        md_resultRDY = 1'b0;
        chk("kill_stall", 32'(stall), 32'd0);
        chk("kill_d", wb_data, 32'd14);
        issue(1'b0, 32'd3, 32'd4, 5'd2);
        step();
        idle_in();
        chk("kill_new_mul", 32'(md_ctrl_MULT), 32'd1);
        chk("kill_new_opa", md_operandA, 32'd3);
        step();
        md_resultRDY = 1'b1;
        md_result    = 32'd12;
        step();
        md_resultRDY = 1'b0;
        chk("kill_new_d", wb_data, 32'd12);
        chk("kill_new_rd", 32'(wb_rd), 32'd2);
        step();
        chk("kill_nwb", 32'(n_wb - base_wb), 32'd1);

        // Kill in DONE suppresses the strobe.
        mark();
        issue(1'b1, 32'd5, 32'd0, 5'd4);
        step();
        idle_in();
        req_kill = 1'b1;
        #1;
        chk("kdone_wbv", 32'(wb_valid), 32'd0);
        step();
        req_kill = 1'b0;
        chk("kdone_nwb", 32'(n_wb - base_wb), 32'd0);

        // Asynchronous reset mid-WAIT.
        mark();
        issue(1'b0, 32'd9, 32'd9, 5'd1);
        step();
        idle_in();
        step();
        step();
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        chk_zero("mrst");
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        md_resultRDY = 1'b1;
        repeat (3) step();
        md_resultRDY = 1'b0;
        chk("mrst_nwb", 32'(n_wb - base_wb), 32'd0);

`ifdef MD_TIMEOUT_EN
        // Watchdog fires after 8 WAIT cycles.
        mark();
        issue(1'b0, 32'd2, 32'd2, 5'd6);
        step();
        idle_in();
        for (int i = 0; i < 8; i++) begin
            step();
        end
        chk("to_wait_nowb", 32'(n_wb - base_wb), 32'd0);
        step();
        chk("to_wbv", 32'(wb_valid), 32'd1);
        chk("to_wbx", 32'(wb_exception), 32'd1);
        chk("to_wbd", wb_data, 32'd0);
        chk("to_flag", 32'(md_timeout), 32'd1);
        step();
        step();
        chk("to_sticky", 32'(md_timeout), 32'd1);
`else
        // No watchdog: still waiting after 100 cycles.
        mark();
        issue(1'b0, 32'd2, 32'd2, 5'd6);
        step();
        idle_in();
        for (int i = 0; i < 100; i++) begin
            step();
        end
        chk("nto_stall", 32'(stall), 32'd1);
        chk("nto_nwb", 32'(n_wb - base_wb), 32'd0);
        chk("nto_flag", 32'(md_timeout), 32'd0);
        req_kill = 1'b1;
        step();
        req_kill = 1'b0;
        chk("nto_kill", 32'(stall), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 Parameters SHALL be:
- RD_W, 5, width of the destination-register tag.
- TIMEOUT_CYCLES, 64, number of WAIT cycles before the watchdog fires (only with MD_TIMEOUT_EN).

REQ-002 Ports SHALL be:
- clock  in  1  single clock; all state updates on its rising edge.
- ctrl_reset_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  pipeline presents a mult/div op this cycle.
- req_is_div  in  1  1 = divide, 0 = multiply.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_rd  in  RD_W  destination tag.
- req_kill  in  1  pipeline flush; aborts the operation in flight.
- stall  out  1  upstream pipeline must hold.
- md_operandA  out  32  registered operand A to the multdiv unit.
- md_operandB  out  32  registered operand B to the multdiv unit.
- md_ctrl_MULT  out  1  multiply start pulse.
- md_ctrl_DIV  out  1  divide start pulse.
- md_result  in  32  multdiv result.
- md_exception  in  1  multdiv exception.
- md_resultRDY  in  1  multdiv result ready.
- wb_valid  out  1  writeback strobe.
- wb_rd  out  RD_W  writeback tag.
- wb_data  out  32  writeback data.
- wb_exception  out  1  writeback exception.
- md_timeout  out  1  sticky watchdog flag.

Function
REQ-003 The FSM SHALL have four states, IDLE, START, WAIT and DONE, and be one-hot or binary-encoded at implementer choice.
REQ-004 A request SHALL be accepted only in IDLE with req_valid=1 and req_kill=0; on acceptance, req_a, req_b, req_rd and req_is_div are latched.
REQ-005 From IDLE on acceptance, the FSM SHALL go to START, except when req_is_div=1 and req_b=0, where it SHALL go to DONE with wb_exception=1 and wb_data=0, and no start pulse is issued.
REQ-006 In START, exactly one of md_ctrl_MULT/md_ctrl_DIV (per the latched op) SHALL be high for exactly one cycle; both SHALL be 0 in every other state.
REQ-007 md_resultRDY SHALL be ignored in START, because a stale ready from a prior op is possible.
REQ-008 From START the FSM SHALL go to WAIT and clear the wait counter.
REQ-009 In WAIT with md_resultRDY=1, the block SHALL capture md_result into wb_data and md_exception into wb_exception, then go to DONE.
REQ-010 md_operandA and md_operandB SHALL hold the latched values, stable, from START through DONE.
REQ-011 In DONE, wb_valid SHALL be 1 for exactly one cycle with wb_rd equal to the latched tag, and the FSM SHALL return to IDLE.
REQ-012 wb_data, wb_rd and wb_exception SHALL hold their values until the next DONE.
REQ-013 stall SHALL be a registered decode equal to 1 in START, WAIT and DONE, and 0 in IDLE.
REQ-014 Minimum latency from acceptance to wb_valid SHALL be 3 cycles (IDLE->START->WAIT->DONE, with ready in the first WAIT cycle); for the divide-by-zero path it SHALL be 1 cycle.
REQ-015 req_kill=1 in START or WAIT SHALL send the FSM to IDLE next cycle with no wb_valid; req_kill in DONE SHALL suppress wb_valid; req_kill has priority over md_resultRDY.
REQ-016 md_resultRDY outside START/WAIT SHALL have no effect.

Reset
REQ-017 With ctrl_reset_n=0, asynchronously, the state SHALL be IDLE and every output SHALL be 0, including md_timeout and the latched operands.
REQ-018 Reset asserted mid-operation SHALL discard the operation with no wb_valid after release.
REQ-019 The first request SHALL be accepted on the first rising edge after release.

Configuration
REQ-020 With MD_TIMEOUT_EN defined, the WAIT counter SHALL count each WAIT cycle without ready.
REQ-021 Under MD_TIMEOUT_EN, on reaching TIMEOUT_CYCLES-1 the FSM SHALL go to DONE with wb_data=0 and wb_exception=1, and md_timeout SHALL set, clearing only on reset.
REQ-022 Without MD_TIMEOUT_EN, the counter SHALL be absent, WAIT SHALL persist until ready or kill, and md_timeout SHALL be tied 0.

Verification
REQ-023 Multiply: a=7, b=-3, mult; ready after 17 WAIT cycles, md_result=-21 -> one START pulse of md_ctrl_MULT, wb_valid once with wb_data=0xFFFFFFEB and wb_exception=0; stall high from START to DONE.
REQ-024 Divide by zero: a=10, b=0, div -> no md_ctrl_DIV pulse, wb_valid on the next cycle with wb_exception=1 and wb_data=0.
REQ-025 Stale ready: md_resultRDY held 1 during START -> ignored; capture on the first WAIT cycle only, 3-cycle latency.
REQ-026 Kill: req_kill pulse in WAIT cycle 5 -> IDLE next cycle, no wb_valid, and a new request is accepted the following cycle.
REQ-027 Reset mid-WAIT: all outputs 0 asynchronously, no wb_valid after release.
REQ-028 MD_TIMEOUT_EN with TIMEOUT_CYCLES=8 and ready never asserted -> DONE after 8 WAIT cycles with wb_exception=1 and md_timeout=1 (sticky); without the macro, still WAIT after 100 cycles.
